// File: rtl/bka_add_arbiter_if.sv
// Operand request channels (one per requester) and the shared, ID-tagged response channel.
interface bka_add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 19,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_chain;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH:0]        rsp_sum;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_x, req_y, req_cin, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_x, req_y, req_cin, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/bka_add_arbiter.sv
// Round-robin share of one Brent-Kung adder: grant -> rsp_valid in 2 cycles, result held until rsp_ready.
// Define BKA_ARB_CHAIN_EN to keep a per-requester carry that req_chain can select as carry-in.
module bka_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 19,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  bka_add_arbiter_if.slave bus
);

  localparam int TOPD = 2 ** ($clog2(WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, gnt_id, nxt_ptr, id_reg;
  logic             gnt_any, grant, cin_sel;
  logic [NREQ-1:0]  ready;
  logic [WIDTH-1:0] op_x, op_y;
  logic             op_cin;
  logic [WIDTH:0]   sum_reg, add_sum;

  // Brent-Kung prefix: up-sweep builds aligned group (G,P), down-sweep fills the gaps.
  function automatic logic [WIDTH:0] bk_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             ci);
    logic [WIDTH-1:0] p, gg, pp;
    logic [WIDTH:0]   s;
    p  = a ^ b;
    gg = a & b;
    pp = p;
    gg[0] = gg[0] | (p[0] & ci);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i - d]);
        pp[i] = pp[i] & pp[i - d];
      end
    end
    for (int d = TOPD; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i - d]);
      end
    end
    s[0] = p[0] ^ ci;
    for (int i = 1; i < WIDTH; i++) begin
      s[i] = p[i] ^ gg[i - 1];
    end
    s[WIDTH] = gg[WIDTH - 1];
    return s;
  endfunction

  assign add_sum = bk_add(op_x, op_y, op_cin);

  // Search from rr_ptr upward; iterating downward lets the nearest valid win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign nxt_ptr = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          grant     = 1'b1;
          ready     = NREQ'(1) << gnt_id;
          state_nxt = CALC;
        end
      end
      CALC: state_nxt = HOLD;
      HOLD: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BKA_ARB_CHAIN_EN
  logic [NREQ-1:0] cy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cy <= '0;
    end else if (state == HOLD && bus.rsp_ready) begin
      cy[id_reg] <= sum_reg[WIDTH];
    end
  end

  assign cin_sel = bus.req_chain[gnt_id] ? cy[gnt_id] : bus.req_cin[gnt_id];
`else
  logic unused_chain;
  assign unused_chain = ^bus.req_chain;
  assign cin_sel      = bus.req_cin[gnt_id];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      id_reg  <= '0;
      op_x    <= '0;
      op_y    <= '0;
      op_cin  <= 1'b0;
      sum_reg <= '0;
    end else begin
      if (grant) begin
        op_x   <= bus.req_x[int'(gnt_id) * WIDTH +: WIDTH];
        op_y   <= bus.req_y[int'(gnt_id) * WIDTH +: WIDTH];
        op_cin <= cin_sel;
        id_reg <= gnt_id;
        rr_ptr <= nxt_ptr;
      end
      if (state == CALC) begin
        sum_reg <= add_sum;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == HOLD);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_id    = id_reg;

endmodule

// File: tb/tb_bka_add_arbiter.sv
// Bench for bka_add_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_bka_add_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 19;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_ptr = 0;
  bit   m_cy [NREQ];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bka_add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  bka_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    longint s;
    s = longint'(x) + longint'(y) + longint'(c);
    return s[WIDTH:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_cin   = '0;
    bus.req_chain = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic set_op(input int r, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic ch);
    bus.req_valid                  = '0;
    bus.req_valid[r]               = 1'b1;
    bus.req_x[r*WIDTH +: WIDTH]    = x;
    bus.req_y[r*WIDTH +: WIDTH]    = y;
    bus.req_cin[r]                 = c;
    bus.req_chain[r]               = ch;
  endtask

  task automatic randomize_operands();
    for (int r = 0; r < NREQ; r++) begin
      bus.req_x[r*WIDTH +: WIDTH] = WIDTH'($urandom);
      bus.req_y[r*WIDTH +: WIDTH] = WIDTH'($urandom);
      bus.req_cin[r]              = 1'($urandom);
      bus.req_chain[r]            = 1'($urandom);
    end
  endtask

  function automatic logic eff_cin(input int r);
`ifdef BKA_ARB_CHAIN_EN
    return bus.req_chain[r] ? logic'(m_cy[r]) : bus.req_cin[r];
`else
    return bus.req_cin[r];
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst   = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cy[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req_valid = '1;
    tick();
    tick();
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_sum !== 20'h0) begin n_fail++; $display("FAIL rst_rsp_sum: got %h expected 00000", bus.rsp_sum); end
    n_tests++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d expected 0", bus.rsp_id); end
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cy[i] = 1'b0;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 0001", bus.req_ready); end
    bus.req_valid = '0;
    tick();
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL withdraw_no_op: got valid %b ready %b expected 0 0000", bus.rsp_valid, bus.req_ready); end
    tick();
  endtask

  task automatic test_carry_out();
    int t0;
    set_op(0, 19'h7FFFF, 19'h00001, 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL co_grant: got %b expected 0001", bus.req_ready); end
    t0 = cyc;
    m_ptr = 1;
    tick();
    bus.req_valid = '0;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL co_calc_valid: got %b expected 0", bus.rsp_valid); end
    tick();
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b1 || cyc - t0 != 2) begin n_fail++; $display("FAIL co_latency: got valid %b after %0d cycles expected 1 after 2", bus.rsp_valid, cyc - t0); end
    n_tests++; if (bus.rsp_sum !== 20'h80000) begin n_fail++; $display("FAIL co_sum: got %h expected 80000", bus.rsp_sum); end
    n_tests++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL co_id: got %0d expected 0", bus.rsp_id); end
    tick();
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] tx [6] = '{19'h7FFFF, 19'h00000, 19'h00000, 19'h7FFFF, 19'h55555, 19'h40000};
    logic [WIDTH-1:0] ty [6] = '{19'h7FFFF, 19'h00000, 19'h00000, 19'h00000, 19'h2AAAA, 19'h40000};
    logic             tc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [WIDTH:0]   es;
    logic [NREQ-1:0]  oh;
    for (int i = 0; i < 6; i++) begin
      set_op(i % NREQ, tx[i], ty[i], tc[i], 1'b0);
      es = ref_sum(tx[i], ty[i], tc[i]);
      oh = NREQ'(1) << (i % NREQ);
      #1;
      n_tests++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL corner_grant[%0d]: got %b expected %b", i, bus.req_ready, oh); end
      m_ptr = (i % NREQ + 1) % NREQ;
      tick();
      bus.req_valid = '0;
      tick();
      #1;
      n_tests++; if (bus.rsp_sum !== es || bus.rsp_id !== IDW'(i % NREQ)) begin n_fail++; $display("FAIL corner_sum[%0d]: got %h id %0d expected %h id %0d", i, bus.rsp_sum, bus.rsp_id, es, i % NREQ); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int grants = 0, resps = 0, last = -1, eg = 0;
    logic [WIDTH:0]  es = '0;
    logic [NREQ-1:0] oh;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.req_valid = (c < 16) ? '1 : '0;
      randomize_operands();
      bus.req_chain = '0;
      #1;
      if (bus.rsp_valid === 1'b1) begin
        resps++;
        n_tests++; if (bus.rsp_sum !== es || bus.rsp_id !== IDW'(eg)) begin n_fail++; $display("FAIL rr_rsp: got %h id %0d expected %h id %0d", bus.rsp_sum, bus.rsp_id, es, eg); end
      end
      if (bus.req_ready !== '0) begin
        eg = pick(bus.req_valid, m_ptr);
        oh = NREQ'(1) << eg;
        n_tests++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL rr_order: got %b expected %b", bus.req_ready, oh); end
        if (last >= 0) begin
          n_tests++; if (cyc - last != 3) begin n_fail++; $display("FAIL rr_gap: got %0d expected 3", cyc - last); end
        end
        last  = cyc;
        es    = ref_sum(bus.req_x[eg*WIDTH +: WIDTH], bus.req_y[eg*WIDTH +: WIDTH], bus.req_cin[eg]);
        m_ptr = (eg + 1) % NREQ;
        grants++;
      end
      tick();
    end
    n_tests++; if (grants != 6 || resps != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants %0d rsps expected 6 6", grants, resps); end
  endtask

  task automatic test_backpressure();
    int r;
    logic [WIDTH:0]  es;
    logic [NREQ-1:0] oh;
    r = $urandom_range(0, NREQ - 1);
    set_op(r, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    es = ref_sum(bus.req_x[r*WIDTH +: WIDTH], bus.req_y[r*WIDTH +: WIDTH], bus.req_cin[r]);
    bus.rsp_ready = 1'b0;
    oh = NREQ'(1) << r;
    #1;
    n_tests++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL bp_grant: got %b expected %b", bus.req_ready, oh); end
    m_ptr = (r + 1) % NREQ;
    tick();
    bus.req_valid = '1;
    tick();
    for (int h = 0; h < 5; h++) begin
      #1;
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== es || bus.rsp_id !== IDW'(r)) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h id %0d expected v1 %h id %0d", h, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, es, r); end
      n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", h, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_accept: got v%b ready %b expected v1 0000", bus.rsp_valid, bus.req_ready); end
    tick();
    oh = NREQ'(1) << pick(bus.req_valid, m_ptr);
    #1;
    n_tests++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL bp_next_grant: got %b expected %b", bus.req_ready, oh); end
    bus.req_valid = '0;
    tick();
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_withdraw: got v%b ready %b expected v0 0000", bus.rsp_valid, bus.req_ready); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH:0] es;
    set_op($urandom_range(0, NREQ - 1), WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0);
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", bus.rsp_valid); end
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cy[i] = 1'b0;
    randomize_operands();
    bus.req_chain = '0;
    bus.req_valid = 4'b1100;
    es = ref_sum(bus.req_x[2*WIDTH +: WIDTH], bus.req_y[2*WIDTH +: WIDTH], bus.req_cin[2]);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0100", bus.req_ready); end
    m_ptr = 3;
    tick();
    bus.req_valid = '0;
    tick();
    #1;
    n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== es || bus.rsp_id !== 2'd2) begin n_fail++; $display("FAIL rst_mid_rsp: got v%b %h id %0d expected v1 %h id 2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id, es); end
    tick();
  endtask

  task automatic test_fairness_skip();
    int              got [$];
    int              eg = 0;
    logic [NREQ-1:0] oh;
    set_op(1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_setup: got %b expected 0010", bus.req_ready); end
    m_ptr = 2;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    for (int c = 0; c < 9; c++) begin
      bus.req_valid = (c < 7) ? 4'b1010 : 4'b0000;
      #1;
      if (bus.req_ready !== '0) begin
        eg = pick(bus.req_valid, m_ptr);
        oh = NREQ'(1) << eg;
        n_tests++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL skip_order: got %b expected %b", bus.req_ready, oh); end
        got.push_back(eg);
        m_ptr = (eg + 1) % NREQ;
      end
      tick();
    end
    n_tests++; if (got.size() != 3 || got[0] != 3 || got[1] != 1 || got[2] != 3) begin n_fail++; $display("FAIL skip_seq: got %p expected 3 1 3", got); end
  endtask

  task automatic test_random();
    bit              outst = 0;
    int              age = 0, eg = 0, g;
    logic [WIDTH:0]  es = '0;
    logic [NREQ-1:0] v, exp_ready;
    logic            exp_rv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = (c < 392) ? NREQ'($urandom) : '0;
      bus.req_valid = v;
      bus.rsp_ready = (c >= 392) ? 1'b1 : ($urandom_range(0, 3) != 0);
      randomize_operands();
      #1;
      g         = pick(v, m_ptr);
      exp_ready = (!outst && g >= 0) ? NREQ'(1) << g : '0;
      exp_rv    = outst && age >= 2;
      n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.req_ready, exp_ready); end
      n_tests++; if (bus.rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, bus.rsp_valid, exp_rv); end
      if (exp_rv) begin
        n_tests++; if (bus.rsp_sum !== es || bus.rsp_id !== IDW'(eg)) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %h id %0d expected %h id %0d", c, bus.rsp_sum, bus.rsp_id, es, eg); end
      end
      if (outst) begin
        if (age >= 2 && bus.rsp_ready) begin
          outst = 0;
          m_cy[eg] = es[WIDTH];
        end else begin
          age++;
        end
      end else if (g >= 0) begin
        eg    = g;
        es    = ref_sum(bus.req_x[g*WIDTH +: WIDTH], bus.req_y[g*WIDTH +: WIDTH], eff_cin(g));
        m_ptr = (g + 1) % NREQ;
        outst = 1;
        age   = 1;
      end
      tick();
    end
  endtask

`ifdef BKA_ARB_CHAIN_EN
  task automatic test_chain();
    int               tr [3] = '{1, 2, 1};
    logic [WIDTH-1:0] tx [3] = '{19'h7FFFF, 19'h12345, 19'h00000};
    logic [WIDTH-1:0] ty [3] = '{19'h00001, 19'h7FFFF, 19'h00000};
    logic             tc [3] = '{1'b0, 1'b0, 1'b0};
    logic             th [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH:0]   es;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_op(tr[i], tx[i], ty[i], tc[i], th[i]);
      es = ref_sum(tx[i], ty[i], eff_cin(tr[i]));
      tick();
      bus.req_valid = '0;
      tick();
      #1;
      n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== es || bus.rsp_id !== IDW'(tr[i])) begin n_fail++; $display("FAIL chain[%0d]: got v%b %h id %0d expected v1 %h id %0d", i, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, es, tr[i]); end
      m_cy[tr[i]] = es[WIDTH];
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_carry_out();
    test_corners();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_fairness_skip();
    test_random();
`ifdef BKA_ARB_CHAIN_EN
    test_chain();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
